// File: rtl/draw_pkg.sv
// Shared definitions for the draw-port arbiter: FSM encoding, requester ids,
// pixel bus widths and the pixel bundle carried from the selected requester.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int REQ_BG      = 0;
    localparam int REQ_STONE   = 1;
    localparam int REQ_GOLD    = 2;
    localparam int REQ_DIAMOND = 3;
    localparam int REQ_HOOK    = 4;
    localparam int REQ_NUM     = 5;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int C_W   = 12;
    localparam int PTR_W = 3;
    localparam int WD_W  = 17;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] color;
        logic           we;
    } pixel_t;

    // Next round-robin start position after index v, wrapping at n.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v, input int n);
        if (int'(v) >= n - 1)
            return '0;
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/draw_port_arbiter_rr_pick.sv
// Round-robin search: first set request at or above ptr, wrapping at N_REQ.
module rr_pick
    import draw_pkg::*;
#(
    parameter int N_REQ = 6
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    logic [PTR_W:0] cand;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(N_REQ))
                cand = cand - (PTR_W+1)'(N_REQ);
            if (!valid && req[cand[PTR_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/draw_port_arbiter.sv
// Single-owner arbiter in front of the VGA pixel port. Define
// DRAW_ARB_TRANSPARENCY_EN to suppress writes of the transparent colour.
module draw_port_arbiter
    import draw_pkg::*;
#(
    parameter int               N_REQ          = 6,
    parameter logic [N_REQ-1:0] TRANSP_MASK    = 6'b111110,
    parameter logic [11:0]      TRANSP_COLOR   = 12'h000,
    parameter int               TIMEOUT_CYCLES = 80000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     done,
    input  logic [N_REQ*X_W-1:0] x_in,
    input  logic [N_REQ*Y_W-1:0] y_in,
    input  logic [N_REQ*C_W-1:0] color_in,
    input  logic [N_REQ-1:0]     we_in,
    output logic [N_REQ-1:0]     grant,
    output logic [X_W-1:0]       X_out,
    output logic [Y_W-1:0]       Y_out,
    output logic [C_W-1:0]       Color_out,
    output logic                 writeEn,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] g;
    logic [WD_W-1:0]  watchdog;

    logic [N_REQ-1:0][X_W-1:0] x_arr;
    logic [N_REQ-1:0][Y_W-1:0] y_arr;
    logic [N_REQ-1:0][C_W-1:0] c_arr;

    assign x_arr = x_in;
    assign y_arr = y_in;
    assign c_arr = color_in;

    // Only the owner's slice is ever selected, so other requesters cannot leak.
    pixel_t pix_sel;
    always_comb begin
        pix_sel       = '0;
        pix_sel.x     = x_arr[g];
        pix_sel.y     = y_arr[g];
        pix_sel.color = c_arr[g];
        pix_sel.we    = we_in[g];
    end

    logic we_eff;
`ifdef DRAW_ARB_TRANSPARENCY_EN
    assign we_eff = pix_sel.we & ~(TRANSP_MASK[g] & (pix_sel.color == TRANSP_COLOR));
`else
    assign we_eff = pix_sel.we;
    logic unused_transp_cfg;
    assign unused_transp_cfg = ^{TRANSP_MASK, TRANSP_COLOR};
`endif

    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    logic wd_hit;
    logic owner_end;
    assign wd_hit    = (watchdog == WD_LAST);
    assign owner_end = done[g] | ~req[g] | wd_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            g           <= '0;
            grant       <= '0;
            X_out       <= '0;
            Y_out       <= '0;
            Color_out   <= '0;
            writeEn     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            watchdog    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    writeEn <= 1'b0;
                    if (pick_valid) begin
                        g        <= pick_idx;
                        grant    <= ONE << pick_idx;
                        watchdog <= '0;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end else begin
                        grant <= '0;
                    end
                end
                GRANT: begin
                    // The pixel of the final owner cycle is still forwarded.
                    X_out     <= pix_sel.x;
                    Y_out     <= pix_sel.y;
                    Color_out <= pix_sel.color;
                    writeEn   <= we_eff;
                    watchdog  <= watchdog + 1'b1;
                    if (owner_end) begin
                        grant <= '0;
                        state <= RELEASE;
                        if (wd_hit)
                            timeout_err <= 1'b1;
                    end
                end
                RELEASE: begin
                    grant   <= '0;
                    writeEn <= 1'b0;
                    rr_ptr  <= wrap_inc(g, N_REQ);
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    grant   <= '0;
                    writeEn <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Directed bench for draw_port_arbiter with a cycle-level reference model.
module tb_draw_port_arbiter;

    localparam int N  = 6;
    localparam int TO = 16;
    localparam logic [N-1:0] TMASK = 6'b111110;
`ifdef DRAW_ARB_TRANSPARENCY_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  req = '0, done = '0, we_in = '0;
    logic [N*9-1:0]  x_in = '0;
    logic [N*8-1:0]  y_in = '0;
    logic [N*12-1:0] color_in = '0;
    logic [N-1:0]  grant;
    logic [8:0]    X_out;
    logic [7:0]    Y_out;
    logic [11:0]   Color_out;
    logic          writeEn, busy, timeout_err;

    int passed = 0;
    int total  = 0;

    draw_port_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .color_in(color_in), .we_in(we_in),
        .grant(grant), .X_out(X_out), .Y_out(Y_out), .Color_out(Color_out),
        .writeEn(writeEn), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: ownership phase 0 free, 1 owned, 2 cool-down.
    function automatic int rr_first(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++)
            if (r[(start + k) % N]) return (start + k) % N;
        return 0;
    endfunction

    int         m_ph = 0, m_g = 0, m_ptr = 0, m_cyc = 0;
    logic [N-1:0] m_grant = '0;
    logic [8:0]  m_x = '0;
    logic [7:0]  m_y = '0;
    logic [11:0] m_c = '0;
    logic        m_we = 0, m_busy = 0, m_terr = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_ph <= 0; m_g <= 0; m_ptr <= 0; m_cyc <= 0; m_grant <= '0;
            m_x <= '0; m_y <= '0; m_c <= '0; m_we <= 0; m_busy <= 0; m_terr <= 0;
        end else if (m_ph == 0) begin
            m_we <= 0;
            if (req != 0) begin
                m_g     <= rr_first(req, m_ptr);
                m_grant <= N'(1) << rr_first(req, m_ptr);
                m_cyc   <= 1;
                m_busy  <= 1;
                m_ph    <= 1;
            end else m_grant <= '0;
        end else if (m_ph == 1) begin
            m_x  <= x_in[m_g*9 +: 9];
            m_y  <= y_in[m_g*8 +: 8];
            m_c  <= color_in[m_g*12 +: 12];
            m_we <= we_in[m_g] && !(TEN && TMASK[m_g] && color_in[m_g*12 +: 12] == 12'h000);
            m_cyc <= m_cyc + 1;
            if (done[m_g] || !req[m_g] || m_cyc == TO) begin
                m_grant <= '0;
                m_ph    <= 2;
                if (m_cyc == TO) m_terr <= 1;
            end
        end else begin
            m_grant <= '0; m_we <= 0; m_busy <= 0;
            m_ptr   <= (m_g + 1) % N;
            m_ph    <= 0;
        end
    end

    always @(negedge clk) begin
        chk("cyc grant", 32'(grant), 32'(m_grant));
        chk("cyc writeEn", 32'(writeEn), 32'(m_we));
        chk("cyc busy", 32'(busy), 32'(m_busy));
        chk("cyc timeout_err", 32'(timeout_err), 32'(m_terr));
        if (m_we) begin
            chk("cyc X_out", 32'(X_out), 32'(m_x));
            chk("cyc Y_out", 32'(Y_out), 32'(m_y));
            chk("cyc Color_out", 32'(Color_out), 32'(m_c));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int i, input int x, input int y, input int c, input bit we);
        x_in[i*9 +: 9]      = 9'(x);
        y_in[i*8 +: 8]      = 8'(y);
        color_in[i*12 +: 12] = 12'(c);
        we_in[i]            = we;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    int n;

    initial begin
        resetn = 1'b0;
        #1;
        do_reset();
        chk("reset grant", 32'(grant), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset X_out", 32'(X_out), 0);
        chk("reset timeout_err", 32'(timeout_err), 0);

        // Background first grant, pixel latency, pixel on done cycle.
        set_pix(1, 300, 200, 12'hFFF, 1);   // non-owner noise
        req = 6'b000001;
        tick();
        chk("bg grant", 32'(grant), 32'h01);
        set_pix(0, 5, 7, 12'hF00, 1);
        tick();
        chk("bg X", 32'(X_out), 5);
        chk("bg Y", 32'(Y_out), 7);
        chk("bg color", 32'(Color_out), 32'hF00);
        chk("bg we", 32'(writeEn), 1);
        set_pix(0, 9, 3, 12'h0F0, 1);
        done = 6'b000001;
        tick();
        chk("done-cycle pixel X", 32'(X_out), 9);
        chk("done-cycle pixel we", 32'(writeEn), 1);
        chk("release grant", 32'(grant), 0);
        done = '0; req = '0; set_pix(0, 0, 0, 0, 0); set_pix(1, 0, 0, 0, 0);
        tick();
        chk("idle we", 32'(writeEn), 0);

        // Round robin from index 0 after reset; two-cycle grant spacing.
        do_reset();
        req = 6'b010100;
        tick();
        chk("rr first", 32'(grant), 32'h04);
        done = 6'b000100;
        tick();
        done = '0; req = 6'b010000;
        chk("rr release", 32'(grant), 0);
        tick();
        chk("rr idle gap", 32'(grant), 0);
        tick();
        chk("rr second", 32'(grant), 32'h10);
        done = 6'b010000;
        tick();
        done = '0; req = '0;
        tick();

        // Abort by dropping req; pointer moves past the aborted requester.
        req = 6'b000010;
        tick();
        chk("abort grant", 32'(grant), 32'h02);
        req = '0;
        done = 6'b000010 ^ 6'b111111; // done from others only, ignored
        tick();
        done = '0;
        chk("abort release", 32'(grant), 0);
        tick();
        req = 6'b000110;
        tick();
        chk("after abort", 32'(grant), 32'h04);
        done = 6'b000100;
        tick();
        done = '0; req = '0;
        tick();

        // Watchdog: owner never finishes.
        req = 6'b001000;
        tick();
        chk("wd grant", 32'(grant), 32'h08);
        n = 1;
        for (int k = 0; k < 40 && grant != 0; k++) begin
            tick();
            if (grant != 0) n++;
        end
        req = '0;
        chk("wd grant cycles", 32'(n), TO);
        chk("wd err", 32'(timeout_err), 1);
        tick(); tick(); tick();
        chk("wd err sticky", 32'(timeout_err), 1);

        // Asynchronous reset in the middle of an ownership.
        set_pix(0, 1, 2, 12'hABC, 1);
        req = 6'b000001;
        tick();
        chk("pre-reset grant", 32'(grant), 32'h01);
        tick();
        chk("pre-reset we", 32'(writeEn), 1);
        #3 resetn = 1'b0;
        #1;
        chk("async grant", 32'(grant), 0);
        chk("async we", 32'(writeEn), 0);
        chk("async err", 32'(timeout_err), 0);
        tick();
        resetn = 1'b1;
        req = 6'b100001;
        tick();
        chk("post-reset grant", 32'(grant), 32'h01);
        req = '0; set_pix(0, 0, 0, 0, 0);
        tick(); tick();

        // Transparent colour on a sprite, then on the background.
        set_pix(1, 20, 30, 12'h000, 1);
        req = 6'b000010;
        tick();
        chk("stone grant", 32'(grant), 32'h02);
        tick();
        chk("stone transp we", 32'(writeEn), TEN ? 0 : 1);
        chk("stone X", 32'(X_out), 20);
        done = 6'b000010;
        tick();
        done = '0; req = '0; set_pix(1, 0, 0, 0, 0);
        tick();
        set_pix(0, 40, 50, 12'h000, 1);
        req = 6'b000001;
        tick();
        chk("bg grant 2", 32'(grant), 32'h01);
        tick();
        chk("bg black we", 32'(writeEn), 1);
        done = 6'b000001;
        tick();
        done = '0; req = '0; set_pix(0, 0, 0, 0, 0);
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
